// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: expands LM/SM into one-hot single-register micro-ops, passes everything else through with one cycle of latency.
module lmsm_sequencer #(
  parameter int LIST_W = 8,
  parameter int IDX_W = 3,
  parameter int OFF_W = 16,
  parameter logic [3:0] OP_LM = 4'b0110,
  parameter logic [3:0] OP_SM = 4'b0111
) (
  input  logic clk,
  input  logic reset,
  input  logic [15:0] ir_in,
  input  logic [15:0] pc_in,
  input  logic valid_in,
  input  logic hold,
  output logic stall_fetch,
  output logic [15:0] ir_out,
  output logic [15:0] pc_out,
  output logic valid_out,
  output logic [IDX_W-1:0] reg_sel,
  output logic [OFF_W-1:0] mem_offset,
  output logic mem_en,
  output logic is_load,
  output logic uop_first,
  output logic uop_last,
  output logic busy
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [LIST_W-1:0] mask, src, low_bit, rest;
  logic [IDX_W-1:0] low_idx;
  logic accept, is_mem;
  assign busy = state == RUN;
  assign stall_fetch = hold | busy;
  assign accept = valid_in & ~stall_fetch;
  assign is_mem = (ir_in[15:12] == OP_LM || ir_in[15:12] == OP_SM) && |ir_in[LIST_W-1:0];
  assign src = busy ? mask : ir_in[LIST_W-1:0];
  always_comb begin
    low_idx = '0;
    for (int i = LIST_W - 1; i >= 0; i--)
      if (src[i]) low_idx = IDX_W'(i);
  end
  assign low_bit = LIST_W'(1) << low_idx;
  assign rest = src & ~low_bit;
  // Upper IR bits and PC stay in the output registers across a sequence, so no separate latch is needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mask <= '0;
      ir_out <= '0;
      pc_out <= '0;
      valid_out <= 1'b0;
      reg_sel <= '0;
      mem_offset <= '0;
      mem_en <= 1'b0;
      is_load <= 1'b0;
      uop_first <= 1'b0;
      uop_last <= 1'b0;
    end else if (!hold) begin
      if (busy) begin
        ir_out <= {ir_out[15:LIST_W], low_bit};
        reg_sel <= low_idx;
        mem_offset <= mem_offset + OFF_W'(1);
        uop_first <= 1'b0;
        uop_last <= rest == '0;
        valid_out <= 1'b1;
        mem_en <= 1'b1;
        mask <= rest;
        state <= rest == '0 ? IDLE : RUN;
      end else if (accept) begin
        ir_out <= is_mem ? {ir_in[15:LIST_W], low_bit} : ir_in;
        pc_out <= pc_in;
        valid_out <= 1'b1;
        reg_sel <= is_mem ? low_idx : '0;
        mem_offset <= '0;
        mem_en <= is_mem;
        is_load <= is_mem && ir_in[15:12] == OP_LM;
        uop_first <= 1'b1;
        uop_last <= !is_mem || rest == '0;
        mask <= is_mem ? rest : '0;
        state <= is_mem && rest != '0 ? RUN : IDLE;
      end else begin
        valid_out <= 1'b0;
        mem_en <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb_lmsm_sequencer: directed spec scenarios plus randomized traffic against a uop-queue reference model.
module tb_lmsm_sequencer;
  logic clk = 0, reset = 1, valid_in = 0, hold = 0;
  logic [15:0] ir_in = 0, pc_in = 0;
  logic stall_fetch, valid_out, mem_en, is_load, uop_first, uop_last, busy;
  logic [15:0] ir_out, pc_out, mem_offset;
  logic [2:0] reg_sel;
  int vectors = 0, errs = 0;

  lmsm_sequencer dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .pc_in(pc_in), .valid_in(valid_in), .hold(hold),
    .stall_fetch(stall_fetch), .ir_out(ir_out), .pc_out(pc_out), .valid_out(valid_out),
    .reg_sel(reg_sel), .mem_offset(mem_offset), .mem_en(mem_en), .is_load(is_load),
    .uop_first(uop_first), .uop_last(uop_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] pc;
    logic v;
    logic [2:0] sel;
    logic [15:0] off;
    logic men, ld, f, l;
  } uop_t;

  uop_t q[$];
  uop_t exp_u, act_u;
  logic m_stall, stall_obs, acc;

  assign act_u = {ir_out, pc_out, valid_out, reg_sel, mem_offset, mem_en, is_load, uop_first, uop_last};

  task automatic expand(input logic [15:0] ir, input logic [15:0] pc);
    uop_t u;
    int n, k;
    logic [7:0] oh;
    n = $countones(ir[7:0]);
    if ((ir[15:12] == 4'd6 || ir[15:12] == 4'd7) && n != 0) begin
      k = 0;
      for (int i = 0; i < 8; i++)
        if (ir[i]) begin
          oh = 8'd1 << i;
          u = '{ir: {ir[15:8], oh}, pc: pc, v: 1'b1, sel: 3'(i), off: 16'(k), men: 1'b1,
                ld: ir[15:12] == 4'd6, f: k == 0, l: k == n - 1};
          q.push_back(u);
          k++;
        end
    end else begin
      u = '{ir: ir, pc: pc, v: 1'b1, sel: 3'd0, off: 16'd0, men: 1'b0, ld: 1'b0, f: 1'b1, l: 1'b1};
      q.push_back(u);
    end
  endtask

  // One clock: drive inputs, capture the pre-edge stall, advance the model, settle 1ns after the edge.
  task automatic tick(input logic v, input logic [15:0] ir, input logic [15:0] pc, input logic h);
    valid_in = v; ir_in = ir; pc_in = pc; hold = h;
    #3;
    stall_obs = stall_fetch;
    m_stall = h | (q.size() != 0);
    acc = v & ~m_stall;
    @(posedge clk);
    if (!h) begin
      if (q.size() != 0) exp_u = q.pop_front();
      else if (v) begin expand(ir, pc); exp_u = q.pop_front(); end
      else begin exp_u.v = 1'b0; exp_u.men = 1'b0; end
    end
    #1;
  endtask

  task automatic test_reset;
    reset = 1; valid_in = 0; hold = 0;
    #2;
    vectors++;
    if ({act_u, busy, stall_fetch} !== '0) begin
      errs++; $display("FAIL reset_state: got %h/%b/%b want all zero", act_u, busy, stall_fetch);
    end
    @(posedge clk); #1;
    reset = 0; q.delete(); exp_u = '0;
  endtask

  task automatic test_lm_basic;
    logic [2:0] sel_w [3] = '{3'd0, 3'd2, 3'd7};
    logic [7:0] oh_w [3] = '{8'h01, 8'h04, 8'h80};
    for (int k = 0; k < 3; k++) begin
      tick(k == 0, 16'h6685, 16'h0100, 0);
      vectors++;
      if ({valid_out, reg_sel, ir_out, mem_offset, uop_first, uop_last, mem_en, is_load, pc_out} !==
          {1'b1, sel_w[k], 8'h66, oh_w[k], 16'(k), k == 0, k == 2, 2'b11, 16'h0100}) begin
        errs++; $display("FAIL lm_basic uop%0d: sel=%0d ir=%h off=%0d f=%b l=%b want sel=%0d ir=66%h off=%0d",
                         k, reg_sel, ir_out, mem_offset, uop_first, uop_last, sel_w[k], oh_w[k], k);
      end
      vectors++;
      if (stall_obs !== (k != 0)) begin
        errs++; $display("FAIL lm_basic_stall uop%0d: got %b want %b", k, stall_obs, k != 0);
      end
    end
    tick(0, 0, 0, 0);
    vectors++;
    if ({stall_obs, valid_out, busy} !== 3'b000) begin
      errs++; $display("FAIL lm_basic_end: stall/valid/busy=%b want 000", {stall_obs, valid_out, busy});
    end
  endtask

  task automatic test_sm_single;
    tick(1, 16'h7010, 16'h0200, 0);
    vectors++;
    if ({valid_out, reg_sel, uop_first, uop_last, mem_en, is_load, ir_out, busy, stall_obs} !==
        {1'b1, 3'd4, 4'b1110, 16'h7010, 2'b00}) begin
      errs++; $display("FAIL sm_single: sel=%0d f=%b l=%b men=%b ld=%b ir=%h busy=%b want sel=4 f=l=men=1 ld=0 ir=7010 busy=0",
                       reg_sel, uop_first, uop_last, mem_en, is_load, ir_out, busy);
    end
    tick(0, 0, 0, 0);
    vectors++;
    if (stall_obs !== 1'b0) begin
      errs++; $display("FAIL sm_single_stall: got %b want 0", stall_obs);
    end
  endtask

  task automatic test_empty_list;
    tick(1, 16'h6000, 16'h0300, 0);
    vectors++;
    if ({valid_out, mem_en, busy, uop_first, uop_last, ir_out, reg_sel} !== {5'b10011, 16'h6000, 3'd0}) begin
      errs++; $display("FAIL empty_list: v=%b men=%b busy=%b ir=%h want v=1 men=0 busy=0 ir=6000",
                       valid_out, mem_en, busy, ir_out);
    end
    tick(0, 0, 0, 0);
    vectors++;
    if ({stall_obs, busy} !== 2'b00) begin
      errs++; $display("FAIL empty_list_idle: stall/busy=%b want 00", {stall_obs, busy});
    end
  endtask

  task automatic test_hold;
    for (int k = 0; k < 3; k++) tick(k == 0, 16'h60FF, 16'h0400, 0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 0, 1);
      vectors++;
      if ({reg_sel, mem_offset, valid_out, stall_obs, busy, ir_out} !== {3'd2, 16'd2, 3'b111, 16'h6004}) begin
        errs++; $display("FAIL hold_freeze c%0d: sel=%0d off=%0d stall=%b ir=%h want sel=2 off=2 stall=1 ir=6004",
                         k, reg_sel, mem_offset, stall_obs, ir_out);
      end
    end
    for (int k = 3; k < 8; k++) begin
      tick(0, 0, 0, 0);
      vectors++;
      if ({reg_sel, mem_offset, uop_last, valid_out} !== {3'(k), 16'(k), k == 7, 1'b1}) begin
        errs++; $display("FAIL hold_resume uop%0d: sel=%0d off=%0d l=%b want sel=%0d off=%0d l=%b",
                         k, reg_sel, mem_offset, uop_last, k, k, k == 7);
      end
    end
    tick(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 4; k++) tick(k == 0, 16'h60FF, 16'h0500, 0);
    #2 reset = 1;
    #1;
    vectors++;
    if ({act_u, busy} !== '0) begin
      errs++; $display("FAIL reset_mid: outs=%h busy=%b want 0", act_u, busy);
    end
    #1 reset = 0;
    q.delete(); exp_u = '0;
    tick(1, 16'h0299, 16'h0600, 0);
    vectors++;
    if ({valid_out, ir_out, pc_out, uop_first, uop_last, mem_en, busy} !== {1'b1, 16'h0299, 16'h0600, 4'b1100}) begin
      errs++; $display("FAIL reset_mid_add: v=%b ir=%h pc=%h men=%b busy=%b want v=1 ir=0299 pc=0600 men=0 busy=0",
                       valid_out, ir_out, pc_out, mem_en, busy);
    end
    tick(0, 0, 0, 0);
  endtask

  task automatic test_back_to_back;
    int adds = 0;
    tick(1, 16'h6603, 16'h0700, 0);
    vectors++;
    if ({reg_sel, uop_first, uop_last} !== {3'd0, 2'b10}) begin
      errs++; $display("FAIL b2b_uop0: sel=%0d f=%b l=%b want 0 1 0", reg_sel, uop_first, uop_last);
    end
    tick(1, 16'h0299, 16'h0701, 0);
    vectors++;
    if ({reg_sel, uop_last, stall_obs, ir_out} !== {3'd1, 2'b11, 16'h6602}) begin
      errs++; $display("FAIL b2b_uop1: sel=%0d l=%b stall=%b ir=%h want 1 1 1 6602", reg_sel, uop_last, stall_obs, ir_out);
    end
    for (int k = 0; k < 3; k++) begin
      tick(k == 0, 16'h0299, 16'h0701, 0);
      if (valid_out && ir_out == 16'h0299) adds++;
      vectors++;
      if (k == 0 && {valid_out, ir_out, pc_out, stall_obs} !== {1'b1, 16'h0299, 16'h0701, 1'b0}) begin
        errs++; $display("FAIL b2b_add: v=%b ir=%h pc=%h stall=%b want 1 0299 0701 0", valid_out, ir_out, pc_out, stall_obs);
      end
    end
    vectors++;
    if (adds != 1) begin
      errs++; $display("FAIL b2b_add_count: got %0d want 1", adds);
    end
  endtask

  task automatic test_random;
    logic [15:0] ir, pc;
    logic [3:0] op;
    logic need = 1;
    for (int c = 0; c < 600; c++) begin
      if (need) begin
        op = 4'($urandom_range(0, 1) ? $urandom_range(6, 7) : $urandom_range(0, 13));
        if (op >= 4'd6 && op <= 4'd13 && $urandom_range(0, 1) == 0) op = op + 4'd2;
        ir = {op, 12'($urandom)};
        if ($urandom_range(0, 7) == 0) ir[7:0] = 8'h00;
        pc = 16'($urandom);
        need = 0;
      end
      tick($urandom_range(0, 3) != 0, ir, pc, $urandom_range(0, 4) == 0);
      if (acc) need = 1;
      vectors++;
      if (stall_obs !== m_stall) begin
        errs++; $display("FAIL rand_stall c%0d: got %b want %b", c, stall_obs, m_stall);
      end
      vectors++;
      if (act_u !== exp_u || busy !== (q.size() != 0)) begin
        errs++; $display("FAIL rand_out c%0d: got %h busy=%b want %h busy=%b", c, act_u, busy, exp_u, q.size() != 0);
      end
    end
  endtask

  initial begin
    test_reset;
    test_lm_basic;
    test_sm_single;
    test_empty_list;
    test_hold;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
